// File: rtl/usb_bus_reset_gen_pkg.sv
// Shared types and speed-derived constants for the USB bus reset generator.
// Flip USB_FULL_SPEED to build the low-speed variant.
package types;

  localparam bit USB_FULL_SPEED = 1'b1;

  localparam int USB_CLK_PER_US = USB_FULL_SPEED ? 48 : 6;
  localparam int USB_BIT_CLKS   = USB_FULL_SPEED ? 4 : 4;

  // J state: FS idles D+ high, LS idles D- high
  localparam bit USB_J_DP = USB_FULL_SPEED;
  localparam bit USB_J_DN = !USB_FULL_SPEED;

  typedef enum logic [1:0] {
    RG_IDLE,
    RG_SE0,
    RG_J,
    RG_RECOVERY
  } bus_reset_state_t;

endpackage

// File: rtl/usb_bus_reset_gen_if.sv
// Port-controller <-> bus reset generator signal bundle.
// slave is the generator side, master the controller side.
interface usb_bus_reset_gen_if;

  logic start_i;
  logic abort_i;
  logic oe_o;
  logic dp_o;
  logic dn_o;
  logic busy_o;
  logic done_o;

  modport master (
    output start_i, abort_i,
    input  oe_o, dp_o, dn_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i,
    output oe_o, dp_o, dn_o, busy_o, done_o
  );

endinterface

// File: rtl/usb_us_timer.sv
// Microsecond time base: prescaler tick plus 16-bit saturating us count.
// clear_i restarts both so each state measures from its own entry.
module usb_us_timer
  import types::*;
(
  input  logic        clk,
  input  logic        clear_i,
  output logic        us_tick_o,
  output logic [15:0] count_o
);

  localparam int PW = $clog2(USB_CLK_PER_US);
  localparam logic [PW-1:0] PRE_LAST = PW'(USB_CLK_PER_US - 1);

  logic [PW-1:0] pre;

  assign us_tick_o = (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (clear_i || us_tick_o) pre <= '0;
    else                      pre <= pre + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clear_i)
      count_o <= '0;
    else if (us_tick_o && count_o != 16'hffff)
      count_o <= count_o + 16'd1;
  end

endmodule

// File: rtl/usb_bus_reset_gen.sv
// Host/hub USB bus reset transmitter: SE0 for RESET_US, one bit of J,
// then bus released for RECOVERY_US before reporting done.
module usb_bus_reset_gen
  import types::*;
#(
  parameter int RESET_US    = 10000,
  parameter int RECOVERY_US = 10000
) (
  input  logic clk,
  input  logic reset_i,
  usb_bus_reset_gen_if.slave bus
);

  if (RESET_US < 1 || RESET_US > 65535) begin : g_bad_reset
    $fatal(1, "RESET_US out of range 1..65535");
  end
  if (RECOVERY_US < 1 || RECOVERY_US > 65535) begin : g_bad_rec
    $fatal(1, "RECOVERY_US out of range 1..65535");
  end

  localparam logic [15:0] SE0_LAST = 16'(RESET_US - 1);
  localparam logic [15:0] REC_LAST = 16'(RECOVERY_US - 1);
  localparam logic [1:0]  J_LAST   = 2'(USB_BIT_CLKS - 1);

  bus_reset_state_t state;
  logic [1:0]  bit_cnt;
  logic [15:0] us;
  logic        tick;
  logic        leave;
  logic        clear;

  usb_us_timer u_timer (
    .clk       (clk),
    .clear_i   (clear),
    .us_tick_o (tick),
    .count_o   (us)
  );

  // leave is asserted in the last cycle of a state; clearing the time
  // base on that same edge makes every state duration an exact count
  always_comb begin
    leave = 1'b0;
    unique case (state)
      RG_IDLE:     leave = bus.start_i;
      RG_SE0:      leave = bus.abort_i ||
                           (tick && us == SE0_LAST);
      RG_J:        leave = (bit_cnt == J_LAST);
      RG_RECOVERY: leave = bus.abort_i ||
                           (tick && us == REC_LAST);
    endcase
  end

  assign clear = reset_i || leave;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= RG_IDLE;
      bit_cnt    <= '0;
      bus.oe_o   <= 1'b0;
      bus.dp_o   <= 1'b0;
      bus.dn_o   <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
    end else begin
      bit_cnt    <= leave ? 2'd0 : bit_cnt + 2'd1;
      bus.done_o <= 1'b0;
      if (leave) begin
        unique case (state)
          RG_IDLE: begin
            state      <= RG_SE0;
            bus.oe_o   <= 1'b1;
            bus.dp_o   <= 1'b0;
            bus.dn_o   <= 1'b0;
            bus.busy_o <= 1'b1;
          end
          RG_SE0: begin
            state    <= RG_J;
            bus.dp_o <= USB_J_DP;
            bus.dn_o <= USB_J_DN;
          end
          RG_J: begin
            state    <= RG_RECOVERY;
            bus.oe_o <= 1'b0;
            bus.dp_o <= 1'b0;
            bus.dn_o <= 1'b0;
          end
          RG_RECOVERY: begin
            state      <= RG_IDLE;
            bus.busy_o <= 1'b0;
            bus.done_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_bus_reset_gen.sv
// Bench for usb_bus_reset_gen: directed scenarios plus random traffic
// against a queue-based expected-waveform model.
module tb_usb_bus_reset_gen;
  import types::*;

  localparam int RST_US = 3;
  localparam int REC_US = 2;
  localparam int N = RST_US * USB_CLK_PER_US;
  localparam int M = REC_US * USB_CLK_PER_US;

  // packed {oe, dp, dn, busy, done}
  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_SE0  = 5'b10010;
  localparam logic [4:0] V_REL  = 5'b00010;
  localparam logic [4:0] V_DONE = 5'b00001;
  localparam logic [4:0] V_J =
    USB_FULL_SPEED ? 5'b11010 : 5'b10110;

  logic clk = 1'b0;
  logic reset;

  usb_bus_reset_gen_if bus ();

  usb_bus_reset_gen #(
    .RESET_US    (RST_US),
    .RECOVERY_US (REC_US)
  ) dut (
    .clk     (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nbusy = 0;
  int ndone = 0;
  logic [4:0] cur = V_IDLE;
  logic [4:0] q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc, got, exp);
    end
  endtask

  // Expected output stream: a whole reset is queued on acceptance,
  // aborts just discard the remainder of the current segment.
  task automatic model(input logic s, input logic a,
                       input logic r);
    if (r) begin
      q.delete();
      cur = V_IDLE;
    end else if (!cur[1]) begin
      if (s) begin
        q.delete();
        repeat (N) q.push_back(V_SE0);
        repeat (4) q.push_back(V_J);
        repeat (M) q.push_back(V_REL);
        q.push_back(V_DONE);
        cur = q.pop_front();
      end else begin
        cur = V_IDLE;
      end
    end else begin
      if (a && cur == V_SE0)
        while (q.size() > 0 && q[0] == V_SE0)
          void'(q.pop_front());
      else if (a && cur == V_REL)
        while (q.size() > 0 && q[0] != V_DONE)
          void'(q.pop_front());
      cur = q.pop_front();
    end
  endtask

  task automatic step(input logic s, input logic a,
                      input logic r);
    bus.start_i = s;
    bus.abort_i = a;
    reset       = r;
    @(posedge clk);
    model(s, a, r);
    @(negedge clk);
    cyc++;
    chk("out",
        {27'd0, bus.oe_o, bus.dp_o, bus.dn_o,
         bus.busy_o, bus.done_o},
        {27'd0, cur});
    nbusy += int'(bus.busy_o);
    ndone += int'(bus.done_o);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    reset       = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b1);
    idle(3);

    // single start pulse, full-length sequence
    nbusy = 0;
    ndone = 0;
    step(1'b1, 1'b0, 1'b0);
    idle(N + M + 20);
    chk("busy_len", nbusy, N + 4 + M);
    chk("done_cnt", ndone, 1);

    // abort at SE0 cycle 50 (clamped for short LS SE0)
    step(1'b1, 1'b0, 1'b0);
    idle((N > 50 ? 50 : N / 2) - 1);
    step(1'b0, 1'b1, 1'b0);
    idle(M + 20);

    // reset mid-SE0, then a full run
    step(1'b1, 1'b0, 1'b0);
    idle((N > 20 ? 20 : N / 2) - 1);
    step(1'b0, 1'b0, 1'b1);
    idle(4);
    nbusy = 0;
    step(1'b1, 1'b0, 1'b0);
    idle(N + M + 10);
    chk("busy_len2", nbusy, N + 4 + M);

    // start held high: back-to-back resets
    ndone = 0;
    for (int i = 0; i < 3 * (N + M + 5); i++)
      step(1'b1, 1'b0, 1'b0);
    chk("held_done", ndone, 3);
    idle(N + M + 10);

    // abort in J ignored, abort at recovery cycle 10 ends it
    step(1'b1, 1'b0, 1'b0);
    idle(N);
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    idle(10);
    step(1'b0, 1'b1, 1'b0);
    idle(10);

    // start and abort together in idle: start wins
    step(1'b1, 1'b1, 1'b0);
    idle(N + M + 10);

    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 299) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
